// File: rtl/randomizer_pkg.sv
// Shared definitions for the XNOR randomizer and its lock checker: width, taps,
// lockup value, checker states and the single next-value function.
package randomizer_pkg;

    localparam int unsigned RAND_WIDTH = 8;

    localparam int unsigned TAP0 = 7;
    localparam int unsigned TAP1 = 5;
    localparam int unsigned TAP2 = 4;
    localparam int unsigned TAP3 = 3;

    localparam logic [RAND_WIDTH-1:0] TAP_MASK =
        RAND_WIDTH'((1 << TAP0) | (1 << TAP1) | (1 << TAP2) | (1 << TAP3));

    // All-ones is the state an XNOR LFSR can never leave, so it never seeds.
    localparam logic [RAND_WIDTH-1:0] LOCKUP_VAL = '1;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } chk_state_e;

    function automatic logic [RAND_WIDTH-1:0] rand_next(input logic [RAND_WIDTH-1:0] v);
        return {v[RAND_WIDTH-2:0], ~^(v & TAP_MASK)};
    endfunction

endpackage

// File: rtl/randomizer_checker_if.sv
// Sample stream into the checker and its status outputs back to the observer.
interface randomizer_checker_if;
    import randomizer_pkg::*;

    logic                  valid_in;
    logic [RAND_WIDTH-1:0] data_in;
    logic                  err_clr_in;
    logic                  locked;
    logic                  error;
    logic [15:0]           err_count;
    logic [1:0]            state;

    modport master (
        output valid_in, data_in, err_clr_in,
        input  locked, error, err_count, state
    );

    modport slave (
        input  valid_in, data_in, err_clr_in,
        output locked, error, err_count, state
    );

endinterface

// File: rtl/lfsr_next.sv
// Combinational one-step advance of the randomizer sequence.
module lfsr_next
    import randomizer_pkg::*;
(
    input  logic [RAND_WIDTH-1:0] value_i,
    output logic [RAND_WIDTH-1:0] next_o
);

    assign next_o = rand_next(value_i);

endmodule

// File: rtl/randomizer_checker.sv
// Tracks an observed randomizer stream: hunts for a seed, verifies a run of correct
// predictions, then counts mispredictions while locked.
module randomizer_checker
    import randomizer_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    randomizer_checker_if.slave  bus
);

    chk_state_e            state_q;
    logic [RAND_WIDTH-1:0] pred_q;
    logic [7:0]            match_cnt_q;
    logic [7:0]            miss_cnt_q;
    logic                  locked_q;
    logic                  error_q;
    logic [15:0]           err_count_q, err_count_d;

    logic [RAND_WIDTH-1:0] data_next;
    logic [RAND_WIDTH-1:0] pred_next;
    logic [7:0]            match_inc;
    logic [7:0]            miss_inc;
    logic                  hit;
    logic                  lock_miss;

    lfsr_next u_next_data (
        .value_i (bus.data_in),
        .next_o  (data_next)
    );

    lfsr_next u_next_pred (
        .value_i (pred_q),
        .next_o  (pred_next)
    );

    assign hit       = (bus.data_in == pred_q);
    assign lock_miss = bus.valid_in && (state_q == StLocked) && !hit;
    assign match_inc = match_cnt_q + 8'd1;
    assign miss_inc  = miss_cnt_q + 8'd1;

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.err_clr_in) begin
            err_count_d = '0;
        end else if (lock_miss && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StHunt;
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            error_q     <= lock_miss;
            err_count_q <= err_count_d;
            if (bus.valid_in) begin
                unique case (state_q)
                    StHunt: begin
                        if (bus.data_in != LOCKUP_VAL) begin
                            pred_q      <= data_next;
                            match_cnt_q <= '0;
                            state_q     <= StVerify;
                        end
                    end
                    StVerify: begin
                        pred_q <= data_next;
                        if (hit) begin
                            match_cnt_q <= match_inc;
                            if (32'(match_inc) == LOCK_COUNT) begin
                                state_q    <= StLocked;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= '0;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                    StLocked: begin
                        if (hit) begin
                            pred_q     <= data_next;
                            miss_cnt_q <= '0;
                        end else begin
                            // Free-run through corruption rather than reseeding from bad data.
                            pred_q     <= pred_next;
                            miss_cnt_q <= miss_inc;
                            if (32'(miss_inc) == LOSS_COUNT) begin
                                state_q  <= StHunt;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= StHunt;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.error     = error_q;
    assign bus.err_count = err_count_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_randomizer_checker.sv
// Scoreboard bench: a default checker and a LOCK=2/LOSS=255 checker for saturation,
// both compared every cycle against a behavioural model of the lock rules.
module tb_randomizer_checker;

    localparam int unsigned LockA = 8;
    localparam int unsigned LossA = 4;
    localparam int unsigned LockB = 2;
    localparam int unsigned LossB = 255;

    typedef struct {
        int         st;
        logic [7:0] pred;
        int         mc;
        int         xc;
        int         ec;
    } mdl_t;

    typedef struct {
        logic        locked;
        logic        error;
        logic [15:0] ec;
        logic [1:0]  st;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    mdl_t       m [2];
    logic [7:0] g [2];
    exp_t       q0 [$];
    exp_t       q1 [$];

    randomizer_checker_if ifa ();
    randomizer_checker_if ifb ();

    randomizer_checker #(
        .LOCK_COUNT (LockA),
        .LOSS_COUNT (LossA)
    ) u_dut (
        .clk_in (clk),
        .rst_in (rst_a),
        .bus    (ifa)
    );

    randomizer_checker #(
        .LOCK_COUNT (LockB),
        .LOSS_COUNT (LossB)
    ) u_sat (
        .clk_in (clk),
        .rst_in (rst_b),
        .bus    (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] nxt(logic [7:0] v);
        return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
    endfunction

    // Reference rules: HUNT=0 seeds on non-FF, VERIFY=1 counts matches, LOCKED=2 counts misses.
    function automatic void step(inout mdl_t t, input bit rst, input bit vld, input bit clr,
                                 input logic [7:0] d, input int lock_n, input int loss_n,
                                 output bit err);
        err = 1'b0;
        if (rst) begin
            t.st = 0; t.pred = 8'h00; t.mc = 0; t.xc = 0; t.ec = 0;
            return;
        end
        if (vld) begin
            if (t.st == 0) begin
                if (d != 8'hFF) begin
                    t.pred = nxt(d); t.mc = 0; t.st = 1;
                end
            end else if (t.st == 1) begin
                if (d == t.pred) begin
                    t.mc = t.mc + 1;
                    if (t.mc == lock_n) begin
                        t.st = 2; t.xc = 0;
                    end
                end else begin
                    t.mc = 0;
                end
                t.pred = nxt(d);
            end else begin
                if (d == t.pred) begin
                    t.pred = nxt(d); t.xc = 0;
                end else begin
                    t.pred = nxt(t.pred); t.xc = t.xc + 1; err = 1'b1;
                    if (t.xc == loss_n) t.st = 0;
                end
            end
        end
        if (clr) t.ec = 0;
        else if (err && t.ec < 65535) t.ec = t.ec + 1;
    endfunction

    task automatic drive(int id, bit rst, bit vld, bit clr, logic [7:0] d);
        mdl_t t;
        exp_t e;
        bit   err;
        @(posedge clk);
        #1;
        if (id == 0) begin
            rst_a = rst; ifa.valid_in = vld; ifa.err_clr_in = clr; ifa.data_in = d;
        end else begin
            rst_b = rst; ifb.valid_in = vld; ifb.err_clr_in = clr; ifb.data_in = d;
        end
        t = m[id];
        step(t, rst, vld, clr, d, (id == 0) ? LockA : LockB, (id == 0) ? LossA : LossB, err);
        m[id] = t;
        e.locked = (t.st == 2);
        e.error  = err;
        e.ec     = 16'(t.ec);
        e.st     = 2'(t.st);
        e.due    = cyc + 1;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic feed(int id, int n);
        for (int i = 0; i < n; i++) begin
            drive(id, 1'b0, 1'b1, 1'b0, g[id]);
            g[id] = nxt(g[id]);
        end
    endtask

    // One idle cycle, then outputs show the effect of the last real sample.
    task automatic settle(int id);
        drive(id, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
    endtask

    task automatic chk(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic cmp(string nm, logic [19:0] got, exp_t e);
        logic [19:0] want;
        want = {e.locked, e.error, e.ec, e.st};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got lk/er/cnt/st=%0b/%0b/%h/%0d want %0b/%0b/%h/%0d",
                     nm, cyc, got[19], got[18], got[17:2], got[1:0],
                     want[19], want[18], want[17:2], want[1:0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                cmp("dut", {ifa.locked, ifa.error, ifa.err_count, ifa.state}, e);
            end
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                cmp("sat", {ifb.locked, ifb.error, ifb.err_count, ifb.state}, e);
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: time limit reached, got %0d cycles", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic run_main();
        int         r;
        logic [7:0] d;
        repeat (2) drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        g[0] = 8'h00;
        feed(0, 8);
        settle(0);
        chk("no_lock_after_8", int'(ifa.locked), 0);
        chk("verify_after_8", int'(ifa.state), 1);
        feed(0, 1);
        settle(0);
        chk("lock_after_9", int'(ifa.locked), 1);
        chk("no_err_on_lock", int'(ifa.err_count), 0);
        feed(0, 3);
        drive(0, 1'b0, 1'b1, 1'b0, g[0] ^ 8'h01);
        g[0] = nxt(g[0]);
        settle(0);
        chk("corrupt_cnt", int'(ifa.err_count), 1);
        chk("corrupt_lock", int'(ifa.locked), 1);
        feed(0, 3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0, g[0] ^ 8'h5A);
            g[0] = nxt(g[0]);
        end
        settle(0);
        chk("loss_state", int'(ifa.state), 0);
        chk("loss_cnt", int'(ifa.err_count), 5);
        chk("loss_lock", int'(ifa.locked), 0);
        repeat (3) drive(0, 1'b0, 1'b1, 1'b0, 8'hFF);
        settle(0);
        chk("ff_hunt", int'(ifa.state), 0);
        feed(0, 8);
        settle(0);
        chk("relock_pending", int'(ifa.locked), 0);
        feed(0, 1);
        settle(0);
        chk("relock", int'(ifa.locked), 1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1) == 1) feed(0, 1);
            else drive(0, 1'b0, 1'b0, 1'b0, 8'($urandom));
        end
        settle(0);
        chk("gap_cnt", int'(ifa.err_count), 5);
        chk("gap_lock", int'(ifa.locked), 1);
        drive(0, 1'b1, 1'b1, 1'b1, g[0]);
        settle(0);
        chk("rst_lock", int'(ifa.locked), 0);
        chk("rst_cnt", int'(ifa.err_count), 0);
        feed(0, 9);
        settle(0);
        chk("post_rst_lock", int'(ifa.locked), 1);
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(7));
            if (r < 4) d = m[0].pred;
            else if (r == 4) d = 8'h00;
            else if (r == 5) d = 8'hFF;
            else d = 8'($urandom);
            drive(0, $urandom_range(63) == 0, $urandom_range(3) != 0,
                  $urandom_range(15) == 0, d);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_sat();
        int k;
        repeat (2) drive(1, 1'b1, 1'b0, 1'b0, 8'h00);
        g[1] = 8'($urandom_range(254));
        feed(1, 3);
        settle(1);
        chk("sat_lock", int'(ifb.locked), 1);
        k = 0;
        while (m[1].ec < 65535) begin
            drive(1, 1'b0, 1'b1, 1'b0, m[1].pred ^ 8'h80);
            k++;
            if (k % 200 == 0) drive(1, 1'b0, 1'b1, 1'b0, m[1].pred);
        end
        repeat (2) drive(1, 1'b0, 1'b1, 1'b0, m[1].pred ^ 8'h80);
        settle(1);
        chk("sat_hold", int'(ifb.err_count), 65535);
        chk("sat_still_locked", int'(ifb.locked), 1);
        drive(1, 1'b0, 1'b1, 1'b1, m[1].pred ^ 8'h80);
        settle(1);
        chk("clr_wins", int'(ifb.err_count), 0);
        drive(1, 1'b0, 1'b1, 1'b0, m[1].pred ^ 8'h80);
        settle(1);
        chk("count_after_clr", int'(ifb.err_count), 1);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin : stim
        ifa.valid_in = 1'b0; ifa.err_clr_in = 1'b0; ifa.data_in = 8'h00;
        ifb.valid_in = 1'b0; ifb.err_clr_in = 1'b0; ifb.data_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m[i].st = 0; m[i].pred = 8'h00; m[i].mc = 0; m[i].xc = 0; m[i].ec = 0;
        end
        fork
            run_main();
            run_sat();
        join
        repeat (3) @(negedge clk);
        chk("drain_dut", q0.size(), 0);
        chk("drain_sat", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
